// File: rtl/riscv_core_mul_iter.sv
// riscv_core_mul_iter: iterative RV32M/RV64M shift-add multiplier (MUL/MULH/MULHSU/MULHU), optional RISCV_CORE_MUL_ZERO_SKIP_EN.
module riscv_core_mul_iter #(
  parameter int XLEN = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_control,
  input  logic [XLEN-1:0] i_srcA,
  input  logic [XLEN-1:0] i_srcB,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);
  localparam int N = XLEN / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, mcand, acc_nxt, prod;
  logic [XLEN-1:0] mplier, mag_a, mag_b;
  logic [1:0] ctrl;
  logic neg, neg_a, neg_b, accept, zero;
  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;
  assign o_busy = state != IDLE;
  assign accept = i_valid & o_ready & ~i_flush;
  assign neg_a = (i_control != 2'b11) & i_srcA[XLEN-1];
  assign neg_b = ~i_control[1] & i_srcB[XLEN-1];
  assign mag_a = neg_a ? -i_srcA : i_srcA;
  assign mag_b = neg_b ? -i_srcB : i_srcB;
  assign acc_nxt = acc + mcand * {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
  assign prod = neg ? -acc_nxt : acc_nxt;
`ifdef RISCV_CORE_MUL_ZERO_SKIP_EN
  assign zero = (i_srcA == '0) | (i_srcB == '0);
`else
  assign zero = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    if (i_flush) state_nxt = IDLE;
    else if (accept) state_nxt = zero ? DONE : CALC;
    else if (state == CALC && cnt == '0) state_nxt = DONE;
    else if (state == DONE && i_ready) state_nxt = IDLE;
  end
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_nxt;
  // multiplicand walks left while the multiplier walks right, so each step adds at the right weight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      ctrl <= '0;
      neg <= 1'b0;
      o_result <= '0;
    end else if (accept) begin
      cnt <= CW'(N - 1);
      acc <= '0;
      mcand <= {{XLEN{1'b0}}, mag_a};
      mplier <= mag_b;
      ctrl <= i_control;
      neg <= neg_a ^ neg_b;
      if (zero) o_result <= '0;
    end else if (state == CALC && !i_flush) begin
      cnt <= cnt - CW'(1);
      acc <= acc_nxt;
      mcand <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
      if (cnt == '0) o_result <= (ctrl == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end
endmodule

// File: tb/tb_riscv_core_mul_iter.sv
// tb_riscv_core_mul_iter: vector table plus scoreboard bench for the iterative multiplier.
module tb_riscv_core_mul_iter;
  localparam int XLEN = 32;
  localparam int BPC = 1;
  localparam int N = XLEN / BPC;
  logic i_clk = 1'b0;
  logic i_rst, i_flush, i_valid, o_ready, i_ready, o_valid, o_busy;
  logic [1:0] i_control;
  logic [XLEN-1:0] i_srcA, i_srcB, o_result;
  always #5 i_clk = ~i_clk;
  riscv_core_mul_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_control(i_control), .i_srcA(i_srcA), .i_srcB(i_srcB), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy)
  );
  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];
  logic [31:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit zs = 1'b0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = (c != 2'b11) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = !c[1] ? longint'($signed(b)) : longint'({32'b0, b});
    p = sa * sb;
    return (c == 2'b00) ? p[31:0] : p[63:32];
  endfunction
  task tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic accept_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int w = 0;
    while (!o_ready && w < 200) begin
      tick();
      w++;
    end
    if (!o_ready) check("ready_timeout", 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_control = c;
    i_srcA = a;
    i_srcB = b;
    tick();
    i_valid = 1'b0;
    i_control = ~c;
    i_srcA = $urandom;
    i_srcB = $urandom;
    q.push_back(exp);
  endtask
  task automatic finish_op(input int exp_lat, input int stall);
    int lat = 1;
    bit bad_ready = 1'b0;
    logic [31:0] held;
    while (!o_valid && lat < 200) begin
      if (o_ready) bad_ready = 1'b1;
      tick();
      lat++;
    end
    check("ready_low_calc", 64'(bad_ready), 64'd0);
    check("latency", 64'(lat), 64'(exp_lat));
    if (!o_valid) return;
    held = o_result;
    for (int i = 0; i < stall; i++) begin
      i_valid = 1'b1;
      tick();
      check("held_valid", 64'(o_valid), 64'd1);
      check("held_result", 64'(o_result), 64'(held));
      check("ready_in_done", 64'(o_ready), 64'd0);
    end
    if (q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
    else check("result", 64'(o_result), 64'(q.pop_front()));
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    i_valid = 1'b0;
    check("valid_drop", 64'(o_valid), 64'd0);
    check("idle_ready", 64'(o_ready), 64'd1);
    if (stall > 0) check("no_accept_at_completion", 64'(o_busy), 64'd0);
  endtask
  task automatic do_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int stall);
    accept_op(c, a, b, exp);
    finish_op((zs && (a == 0 || b == 0)) ? 1 : N + 1, stall);
  endtask
  initial begin
    logic [1:0] c;
    logic [31:0] a, b;
    bit seen;
    int w;
`ifdef RISCV_CORE_MUL_ZERO_SKIP_EN
    zs = 1'b1;
`endif
    tbl[0] = '{2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB};
    tbl[1] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[2] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[4] = '{2'b10, 32'd2, 32'h80000000, 32'h00000001};
    tbl[5] = '{2'b00, 32'd6, 32'd7, 32'h0000002A};
    tbl[6] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    tbl[7] = '{2'b00, 32'd0, 32'h1234, 32'h00000000};
    tbl[8] = '{2'b01, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF};
    tbl[9] = '{2'b11, 32'h80000000, 32'd2, 32'h00000001};
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_control = '0; i_srcA = '0; i_srcB = '0;
    tick();
    tick();
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_result", 64'(o_result), 64'd0);
    i_rst = 1'b0;
    foreach (tbl[i]) do_op(tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].exp, 0);
    for (int i = 0; i < 8; i++) begin
      c = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      do_op(c, a, b, model(c, a, b), 0);
    end
    do_op(2'b00, 32'd3, 32'd5, 32'h0000000F, 10);
    accept_op(2'b00, 32'd9, 32'd9, 32'd81);
    repeat (4) tick();
    i_flush = 1'b1;
    i_valid = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    void'(q.pop_back());
    check("flush_calc_valid", 64'(o_valid), 64'd0);
    check("flush_calc_ready", 64'(o_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      if (o_valid) seen = 1'b1;
      tick();
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_control = 2'b00; i_srcA = 32'd4; i_srcB = 32'd4;
    tick();
    i_valid = 1'b0;
    i_flush = 1'b0;
    check("flush_vs_valid_busy", 64'(o_busy), 64'd0);
    check("flush_vs_valid_ready", 64'(o_ready), 64'd1);
    accept_op(2'b00, 32'd11, 32'd11, 32'd121);
    w = 0;
    while (!o_valid && w < 200) begin
      tick();
      w++;
    end
    check("flush_done_reached", 64'(o_valid), 64'd1);
    i_ready = 1'b1;
    i_flush = 1'b1;
    tick();
    i_ready = 1'b0;
    i_flush = 1'b0;
    void'(q.pop_back());
    check("flush_done_valid", 64'(o_valid), 64'd0);
    check("flush_done_ready", 64'(o_ready), 64'd1);
    do_op(2'b00, 32'd6, 32'd7, 32'h0000002A, 0);
    accept_op(2'b01, 32'h12345678, 32'h9ABCDEF0, 32'd0);
    repeat (3) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    void'(q.pop_back());
    check("midrst_ready", 64'(o_ready), 64'd1);
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_result", 64'(o_result), 64'd0);
    do_op(2'b11, 32'd0, 32'h1234, 32'd0, 0);
    do_op(2'b00, 32'hFFFFFFFF, 32'd0, 32'd0, 2);
    check("sb_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/riscv_core_mul_iter.md
Name: riscv_core_mul_iter

Overview:
- Multi-cycle iterative RV32M/RV64M multiply unit for the EX stage. Handles MUL, MULH, MULHSU and MULHU.
- Operands are converted to magnitudes at accept. The unit then runs a shift-add loop, retiring BITS_PER_CYCLE multiplier bits per cycle.
- The sign is corrected once at the end, and the low or high half is selected.
- Uses valid/ready handshakes on both sides so the hazard unit can stall on it. Accepts a flush from the pipeline kill logic.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration. Legal values: 1, 2, 4, 8; must divide XLEN.

Ports:
- i_clk  input  1  core clock, all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_flush  input  1  abort any in-flight or pending operation.
- i_valid  input  1  operation request.
- o_ready  output  1  unit can accept a request (state IDLE).
- i_control  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- i_srcA  input  XLEN  rs1 operand.
- i_srcB  input  XLEN  rs2 operand.
- o_valid  output  1  o_result valid.
- i_ready  input  1  consumer accepts result.
- o_result  output  XLEN  selected product half.
- o_busy  output  1  state is CALC or DONE.

Behaviour:
- Definitions:
  - N = XLEN/BITS_PER_CYCLE.
  - Accept = i_valid & o_ready & !i_flush.
  - Completion = o_valid & i_ready.
- States:
  - IDLE: o_ready=1.
  - CALC: iteration counter runs N-1 down to 0.
  - DONE: o_valid=1.
- Reset:
  - Goes to IDLE.
  - o_valid=0, o_result=0, o_busy=0, counter=0, accumulator=0, o_ready=1.
- Operand signedness on accept:
  - A signed for MUL, MULH, MULHSU.
  - B signed for MUL, MULH.
  - A signed operand is negative when its bit XLEN-1 is set. Unsigned operands are never negative.
- Accept actions:
  - Latch mag_A and mag_B as XLEN-bit unsigned magnitudes; two's-complement negate when negative (0x80..0 stays 0x80..0).
  - Latch neg = negA ^ negB.
  - Latch the control code.
  - Clear the 2*XLEN accumulator.
  - Go to CALC.
- CALC iteration, every cycle:
  - acc += mag_A * (low BITS_PER_CYCLE bits of multiplier), shifted into position.
  - Multiplier shifts right by BITS_PER_CYCLE.
  - On counter==0, go to DONE.
- Entering DONE, registered:
  - p = neg ? (~acc + 1) mod 2^(2*XLEN) : acc.
  - o_result = p[XLEN-1:0] for MUL, otherwise p[2*XLEN-1:XLEN].
- Latency: accept in cycle 0 → o_valid high in cycle N+1 (33 for XLEN=32, B=1).
- DONE:
  - o_result and o_valid are held stable until completion.
  - On completion, go to IDLE; o_valid low next cycle.
  - No new accept in the same cycle as completion; o_ready=0 in DONE.
- Flush:
  - i_flush in any state → IDLE next cycle; o_valid=0; result discarded.
  - Flush with i_valid in the same cycle: flush wins, no accept.
  - Flush takes priority over completion.
- Reset mid-operation: identical to the reset values above; the partial result is lost.
- Inputs i_srcA, i_srcB and i_control are sampled only at accept. Later changes have no effect.

Optional Feature:
- Macro: RISCV_CORE_MUL_ZERO_SKIP_EN.
- When defined:
  - At accept, if i_srcA==0 or i_srcB==0, skip CALC and go directly to DONE with o_result=0.
  - o_valid is high in cycle 1 after accept.
  - Flush and handshake rules are unchanged.
- When undefined: zero operands take the full N+1 latency; result is 0.

Test Plan:
- MUL, A=7, B=0xFFFFFFFD (-3), i_ready=1 → o_result=0xFFFFFFEB; o_valid exactly N+1 cycles after accept; o_ready low throughout.
- MULH, A=B=0x80000000 → o_result=0x40000000. MULHU, A=B=0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU, A=0xFFFFFFFF (-1), B=0xFFFFFFFF (unsigned) → o_result=0xFFFFFFFF. MULHSU, A=2, B=0x80000000 → 0x00000001.
- Backpressure: MUL 3×5 with i_ready=0 for 10 cycles after o_valid → o_result=0x0000000F held stable; IDLE one cycle after i_ready=1; a new i_valid is ignored while in DONE.
- Flush at CALC cycle 5 (and separately with i_valid in the same cycle) → o_valid never asserts, o_ready=1 next cycle; a following MUL 6×7 returns 0x0000002A at normal latency.
- Synchronous i_rst asserted mid-CALC → all outputs at reset values next edge. With ZERO_SKIP_EN: MULHU 0×0x1234 → o_valid in cycle 1, o_result=0.
